// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Ops: compare, signed/unsigned multiply, subtract with carry.
// Operands are taken on a start/busy/done handshake; multiplies use an iterative shift-add datapath.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, Op       - request (sampled in IDLE) and operation select
//   A, B, Cin       - operands and subtract carry-in, captured at start
//   busy, done      - operation in progress / one-cycle completion pulse
//   R, R_hi, C      - result low half, high half, flag
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R_hi,
    output logic             C
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             sgn_op;
    logic             neg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_next;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   hi_fin;
    logic [WIDTH-1:0]   lo_fin;

    always_comb begin
        // Most negative value maps to itself, which is correct read as unsigned.
        a_mag = A[WIDTH-1] ? -A : A;
        b_mag = B[WIDTH-1] ? -B : B;
        a_ext = {1'b0, A} + {{WIDTH{1'b0}}, Cin};
        b_ext = {1'b0, B};
        diff  = A - B + {{(WIDTH-1){1'b0}}, Cin};
        // {hi, lo}: hi accumulates partial sums, lo shifts out the multiplier.
        sum       = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_next = {sum, lo[WIDTH-1:1]};
        prod_fin  = neg ? -prod_next : prod_next;
        hi_fin    = prod_fin[2*WIDTH-1:WIDTH];
        lo_fin    = prod_fin[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            R      <= '0;
            R_hi   <= '0;
            C      <= 1'b0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            sgn_op <= 1'b0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (Op)
                            2'd0: begin
                                R     <= '0;
                                R_hi  <= '0;
                                C     <= (A <= B);
                                state <= DONE;
                            end
                            2'd3: begin
                                R     <= diff;
                                R_hi  <= '0;
                                C     <= (a_ext >= b_ext);
                                state <= DONE;
                            end
                            default: begin
                                sgn_op <= (Op == 2'd1);
                                if (Op == 2'd1) begin
                                    mcand <= b_mag;
                                    lo    <= a_mag;
                                    neg   <= A[WIDTH-1] ^ B[WIDTH-1];
                                end else begin
                                    mcand <= B;
                                    lo    <= A;
                                    neg   <= 1'b0;
                                end
                                hi    <= '0;
                                cnt   <= '0;
                                busy  <= 1'b1;
                                state <= MUL;
                            end
                        endcase
                    end
                end
                MUL: begin
                    hi  <= prod_next[2*WIDTH-1:WIDTH];
                    lo  <= prod_next[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        R    <= lo_fin;
                        R_hi <= hi_fin;
                        // Signed overflow: high half is not a sign extension of the low half.
                        C     <= sgn_op ? (hi_fin != {WIDTH{lo_fin[WIDTH-1]}})
                                        : (hi_fin != '0);
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu (WIDTH=8) using a result scoreboard.
module tb_seq_alu;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] Op;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] R;
    logic [7:0] R_hi;
    logic       C;

    typedef struct {
        logic [7:0] r;
        logic [7:0] rhi;
        logic       c;
        int         due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Op   (Op),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .R    (R),
        .R_hi (R_hi),
        .C    (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic cin,
                                  output logic [7:0] r, output logic [7:0] rhi,
                                  output logic c);
        int p;
        int t;
        r = 8'h00;
        rhi = 8'h00;
        c = 1'b0;
        case (op)
            2'd0: c = (a <= b);
            2'd1: begin
                p = int'($signed(a)) * int'($signed(b));
                r = p[7:0];
                rhi = p[15:8];
                c = (p > 127) || (p < -128);
            end
            2'd2: begin
                p = int'(a) * int'(b);
                r = p[7:0];
                rhi = p[15:8];
                c = (p > 255);
            end
            default: begin
                t = int'(a) - int'(b) + int'(cin);
                r = t[7:0];
                c = (int'(a) + int'(cin)) >= int'(b);
            end
        endcase
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = q.pop_front();
            chk({tag, "_R"}, R, e.r);
            chk({tag, "_Rhi"}, R_hi, e.rhi);
            chk({tag, "_C"}, C, e.c);
            chk({tag, "_lat"}, cyc, e.due);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [7:0] er,
                          input logic [7:0] erh, input logic ec);
        int  n;
        int  lat;
        logic got;
        lat = (op == 2'd1 || op == 2'd2) ? 9 : 1;
        @(negedge clk);
        start = 1'b1;
        Op = op;
        A = a;
        B = b;
        Cin = cin;
        @(posedge clk);
        @(negedge clk);
        n = cyc;
        start = 1'b0;
        A = ~a;
        B = ~b;
        Cin = ~cin;
        q.push_back('{er, erh, ec, n + lat});
        if (lat > 1) chk({tag, "_busy"}, busy, 1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) begin
                pop_check(tag);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk({tag, "_timeout"}, got, 1);
    endtask

    task automatic run_rand(input int k);
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] er;
        logic [7:0] erh;
        logic       ec;
        op = 2'($urandom_range(0, 3));
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        model(op, a, b, cin, er, erh, ec);
        run_op($sformatf("rand%0d", k), op, a, b, cin, er, erh, ec);
    endtask

    initial begin
        int n;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        Op = 2'd0;
        A = 8'h00;
        B = 8'h00;
        Cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_R", R, 0);
        chk("rst_Rhi", R_hi, 0);
        chk("rst_C", C, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("cmp_eq", 2'd0, 8'd9, 8'd9, 1'b0, 8'h00, 8'h00, 1'b1);
        run_op("cmp_gt", 2'd0, 8'd10, 8'd9, 1'b0, 8'h00, 8'h00, 1'b0);
        run_op("cmp_uns", 2'd0, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b0);
        run_op("umul", 2'd2, 8'd200, 8'd3, 1'b0, 8'h58, 8'h02, 1'b1);

        // Reset during a multiply: outputs clear at once and no done follows.
        @(negedge clk);
        start = 1'b1;
        Op = 2'd1;
        A = 8'h7F;
        B = 8'h7F;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_pre_busy", busy, 1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_R", R, 0);
        chk("midrst_Rhi", R_hi, 0);
        chk("midrst_C", C, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", done_cnt, d0);

        run_op("smul_neg", 2'd1, 8'hFD, 8'd5, 1'b0, 8'hF1, 8'hFF, 1'b0);
        run_op("smul_min", 2'd1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h40, 1'b1);
        run_op("umul_zero", 2'd2, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        run_op("sub_borrow", 2'd3, 8'd5, 8'd7, 1'b1, 8'hFF, 8'h00, 1'b0);
        run_op("sub_plain", 2'd3, 8'd7, 8'd5, 1'b0, 8'h02, 8'h00, 1'b1);
        run_op("sub_cin", 2'd3, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'h00, 1'b1);

        for (int k = 0; k < 12; k++) run_rand(k);

        // Start held high: ops accepted every 10 cycles, one done per op.
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1;
        Op = 2'd2;
        A = 8'd200;
        B = 8'd3;
        Cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n = cyc;
        for (int j = 0; j < 3; j++) q.push_back('{8'h58, 8'h02, 1'b1, n + 9 + 10 * j});
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("hs_done%0d", k), done, (k % 10 == 9));
            if (done) pop_check("hs");
            if (k == 29) start = 1'b0;
            else @(negedge clk);
        end
        repeat (12) @(negedge clk);
        chk("hs_pulses", done_cnt - d0, 3);
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
